memory_multiport: RTL and testbench

//  Byte-masked synchronous RAM, one write port, NUM_READ independent read ports.

---
 rtl/memory_multiport_pkg.sv | 23 ++
 rtl/memory_multiport_if.sv | 32 +++
 rtl/memory_multiport_read_pipe.sv | 51 +++++
 rtl/memory_multiport.sv | 123 ++++++++++++
 tb/tb_memory_multiport.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_multiport_pkg.sv
// Shared types and helpers for the multiport RAM: controller states and byte-mask expansion.
// No timing of its own.
// Used by the top-level RAM only.
package memory_pkg;

  localparam int MAX_BYTES = 16;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  // Widen a per-byte enable vector into a per-bit mask; callers cast down to their own width.
  function automatic logic [MAX_BYTES*8-1:0] expand_mask(input logic [MAX_BYTES-1:0] bytes);
    logic [MAX_BYTES*8-1:0] bits;
    bits = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      bits[i*8 +: 8] = {8{bytes[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/memory_multiport_if.sv
// Bus bundle for the multiport RAM: one write port, NUM_READ read ports, busy flag.
// Pure wiring, no latency.
// No backpressure: requests are accepted every cycle unless busy_out is high.
interface memory_multiport_if #(
  parameter int MEM_WIDTH_BYTES = 4,
  parameter int MEM_DEPTH       = 64,
  parameter int NUM_READ        = 2
);
  localparam int DW = MEM_WIDTH_BYTES * 8;
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic                       write_in;
  logic [AW-1:0]              write_addr_in;
  logic [DW-1:0]              write_data_in;
  logic [MEM_WIDTH_BYTES-1:0] write_mask_in;
  logic [NUM_READ-1:0]        read_in;
  logic [NUM_READ*AW-1:0]     read_addr_in;
  logic [NUM_READ*DW-1:0]     read_data_out;
  logic [NUM_READ-1:0]        read_valid_out;
  logic                       busy_out;

  modport master (
    output write_in, write_addr_in, write_data_in, write_mask_in, read_in, read_addr_in,
    input  read_data_out, read_valid_out, busy_out
  );

  modport slave (
    input  write_in, write_addr_in, write_data_in, write_mask_in, read_in, read_addr_in,
    output read_data_out, read_valid_out, busy_out
  );

endinterface

// File: rtl/memory_multiport_read_pipe.sv
// One read port's delay line: valid and captured word shifted LATENCY stages.
// Latency LATENCY cycles (0 = straight through).
// No backpressure; reset flushes all stages, idle cycles hold the last word.
module memory_read_pipe #(
  parameter int DW      = 32,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_vld,
  input  logic [DW-1:0] req_dat,
  output logic          rd_vld,
  output logic [DW-1:0] rd_dat
);

  if (LATENCY == 0) begin : g_comb
    // Clock and reset have nothing to drive when the port is combinational.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign rd_vld = req_vld;
    assign rd_dat = req_dat;
  end else begin : g_reg
    logic [LATENCY-1:0] vld_q;
    logic [DW-1:0]      dat_q [LATENCY];

    // Shift valid every cycle; a data stage only loads behind a valid so idle ports hold their word.
    always_ff @(posedge clk) begin
      if (!reset) begin
        vld_q <= '0;
        for (int i = 0; i < LATENCY; i++) begin
          dat_q[i] <= '0;
        end
      end else begin
        vld_q[0] <= req_vld;
        if (req_vld) begin
          dat_q[0] <= req_dat;
        end
        for (int i = 1; i < LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) begin
            dat_q[i] <= dat_q[i-1];
          end
        end
      end
    end

    assign rd_vld = vld_q[LATENCY-1];
    assign rd_dat = dat_q[LATENCY-1];
  end

endmodule

// File: rtl/memory_multiport.sv
// Byte-masked RAM, one write port, NUM_READ read ports, optional zero-fill after reset.
// Read latency READ_LATENCY (0/1/2) cycles; writes land at the next clock edge.
// No backpressure; all strobes are ignored while busy_out is high.
module memory_multiport
  import memory_pkg::*;
#(
  parameter int MEM_WIDTH_BYTES = 4,
  parameter int MEM_DEPTH       = 64,
  parameter int NUM_READ        = 2,
  parameter int READ_LATENCY    = 1,
  parameter bit RDW_NEW         = 1'b0,
  parameter bit INIT_CLEAR      = 1'b1
) (
  input logic               clk,
  input logic               reset,
  input logic               debugen_in,
  memory_multiport_if.slave bus
);

  localparam int              DW        = MEM_WIDTH_BYTES * 8;
  localparam int              AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_LIM = (AW+1)'(MEM_DEPTH);
  localparam logic [AW-1:0]   LAST_PTR  = AW'(MEM_DEPTH - 1);

  mem_state_e          state;
  logic [AW-1:0]       clear_ptr;
  logic [DW-1:0]       buffer [MEM_DEPTH];

  logic                wr_in_range;
  logic                wr_en;
  logic [DW-1:0]       wr_bits;
  logic [DW-1:0]       wr_old;
  logic [DW-1:0]       wr_merged;
  logic [NUM_READ-1:0] rd_vld;
  logic [DW-1:0]       rd_dat [NUM_READ];

  assign bus.busy_out = (state == CLEAR);

  // Write merge: untouched bytes keep the stored value; out-of-range addresses never commit.
  assign wr_bits     = DW'(expand_mask(MAX_BYTES'(bus.write_mask_in)));
  assign wr_in_range = ({1'b0, bus.write_addr_in} < DEPTH_LIM);
  assign wr_old      = wr_in_range ? buffer[bus.write_addr_in] : '0;
  assign wr_merged   = (wr_old & ~wr_bits) | (bus.write_data_in & wr_bits);
  assign wr_en       = reset && (state == READY) && bus.write_in && wr_in_range
                       && (|bus.write_mask_in);

  // Controller: stay in CLEAR from reset until every word has been zeroed once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= INIT_CLEAR ? CLEAR : READY;
      clear_ptr <= '0;
    end else if (state == CLEAR) begin
      if (clear_ptr == LAST_PTR) begin
        state     <= READY;
        clear_ptr <= '0;
      end else begin
        clear_ptr <= clear_ptr + AW'(1);
      end
    end
  end

  // Storage: the clear sequencer owns the array while busy, otherwise the write port does.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == CLEAR) begin
        buffer[clear_ptr] <= '0;
      end else if (wr_en) begin
        buffer[bus.write_addr_in] <= wr_merged;
      end
    end
  end

  // Per-port lookup: range check, optional same-cycle forward of the merged word, then delay line.
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          in_range;
    logic          fwd;
    logic          req_vld;
    logic [DW-1:0] word;

    assign addr     = bus.read_addr_in[p*AW +: AW];
    assign in_range = ({1'b0, addr} < DEPTH_LIM);
    assign fwd      = RDW_NEW && wr_en && (bus.write_addr_in == addr);
    assign word     = !in_range ? '0 : (fwd ? wr_merged : buffer[addr]);
    assign req_vld  = bus.read_in[p] && (state == READY);

    memory_read_pipe #(
      .DW      (DW),
      .LATENCY (READ_LATENCY)
    ) u_pipe (
      .clk     (clk),
      .reset   (reset),
      .req_vld (req_vld),
      .req_dat (word),
      .rd_vld  (rd_vld[p]),
      .rd_dat  (rd_dat[p])
    );
  end

  // Pack per-port results onto the flat output buses.
  always_comb begin
    bus.read_data_out = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      bus.read_data_out[p*DW +: DW] = rd_dat[p];
    end
  end

  assign bus.read_valid_out = rd_vld;

  // Trace: one line per cycle describing both port sides and the busy flag.
  always_ff @(posedge clk) begin
    if (debugen_in) begin
      $write("memory_multiport: wr=%b a=%0d d=%h m=%b", bus.write_in, bus.write_addr_in,
             bus.write_data_in, bus.write_mask_in);
      for (int p = 0; p < NUM_READ; p++) begin
        $write(" | rd%0d=%b a=%0d d=%h v=%b", p, bus.read_in[p], bus.read_addr_in[p*AW +: AW],
               bus.read_data_out[p*DW +: DW], bus.read_valid_out[p]);
      end
      $write(" | busy=%b\n", bus.busy_out);
    end
  end

endmodule

// File: tb/tb_memory_multiport.sv
// Bench for the multiport RAM: three configurations driven by one shared stimulus stream.
// Expected read results are queued at request time and checked by a negedge monitor.
// No backpressure on the DUT side; the monitor checks every cycle.
`timescale 1ns/1ps
module tb_memory_multiport;

  localparam int ND = 3;
  localparam int NP = 2;

  typedef struct {
    int          due;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        debugen;
  logic        w_in;
  logic [5:0]  w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_mask;
  logic [1:0]  r_in;
  logic [11:0] r_addr;

  logic [1:0]  vld  [ND];
  logic [63:0] dat  [ND];
  logic        busy [ND];

  logic [31:0] mem [ND][64];
  exp_t        sbq [ND][NP][$];
  logic [31:0] last [ND][NP];
  int          busy_cnt [ND];
  int          cyc = 0;
  logic        rst_q = 1'b0;
  bit          mon_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  memory_multiport_if #(.MEM_WIDTH_BYTES(4), .MEM_DEPTH(64), .NUM_READ(2)) if0 ();
  memory_multiport_if #(.MEM_WIDTH_BYTES(4), .MEM_DEPTH(48), .NUM_READ(2)) if1 ();
  memory_multiport_if #(.MEM_WIDTH_BYTES(4), .MEM_DEPTH(48), .NUM_READ(2)) if2 ();

  assign if0.write_in = w_in;   assign if1.write_in = w_in;   assign if2.write_in = w_in;
  assign if0.write_addr_in = w_addr; assign if1.write_addr_in = w_addr; assign if2.write_addr_in = w_addr;
  assign if0.write_data_in = w_data; assign if1.write_data_in = w_data; assign if2.write_data_in = w_data;
  assign if0.write_mask_in = w_mask; assign if1.write_mask_in = w_mask; assign if2.write_mask_in = w_mask;
  assign if0.read_in = r_in;    assign if1.read_in = r_in;    assign if2.read_in = r_in;
  assign if0.read_addr_in = r_addr; assign if1.read_addr_in = r_addr; assign if2.read_addr_in = r_addr;

  assign vld[0] = if0.read_valid_out; assign dat[0] = if0.read_data_out; assign busy[0] = if0.busy_out;
  assign vld[1] = if1.read_valid_out; assign dat[1] = if1.read_data_out; assign busy[1] = if1.busy_out;
  assign vld[2] = if2.read_valid_out; assign dat[2] = if2.read_data_out; assign busy[2] = if2.busy_out;

  memory_multiport #(.MEM_WIDTH_BYTES(4), .MEM_DEPTH(64), .NUM_READ(2), .READ_LATENCY(1),
                     .RDW_NEW(1'b0), .INIT_CLEAR(1'b1))
    dut0 (.clk(clk), .reset(reset), .debugen_in(debugen), .bus(if0.slave));
  memory_multiport #(.MEM_WIDTH_BYTES(4), .MEM_DEPTH(48), .NUM_READ(2), .READ_LATENCY(2),
                     .RDW_NEW(1'b1), .INIT_CLEAR(1'b1))
    dut1 (.clk(clk), .reset(reset), .debugen_in(1'b0), .bus(if1.slave));
  memory_multiport #(.MEM_WIDTH_BYTES(4), .MEM_DEPTH(48), .NUM_READ(2), .READ_LATENCY(0),
                     .RDW_NEW(1'b1), .INIT_CLEAR(1'b1))
    dut2 (.clk(clk), .reset(reset), .debugen_in(1'b0), .bus(if2.slave));

  function automatic int dep(input int d);
    return (d == 0) ? 64 : 48;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 0);
  endfunction

  function automatic bit rdw(input int d);
    return d != 0;
  endfunction

  // Masked bytes come from the new data, all others from the old word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = m[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // Monitor: every cycle each port either delivers its queued word on time or stays idle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < ND; d++) begin
        for (int p = 0; p < NP; p++) begin
          if (!rst_q) last[d][p] = '0;
          while (sbq[d][p].size() > 0 && sbq[d][p][0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_read dut%0d port%0d: due cycle %0d never delivered", d, p,
                     sbq[d][p][0].due);
            void'(sbq[d][p].pop_front());
          end
          if (sbq[d][p].size() > 0 && sbq[d][p][0].due == cyc) begin
            chk($sformatf("valid_hi dut%0d p%0d", d, p), 64'(vld[d][p]), 64'd1);
            chk($sformatf("rdata dut%0d p%0d", d, p), 64'(dat[d][p*32 +: 32]),
                64'(sbq[d][p][0].dat));
            last[d][p] = sbq[d][p][0].dat;
            void'(sbq[d][p].pop_front());
          end else begin
            chk($sformatf("valid_lo dut%0d p%0d", d, p), 64'(vld[d][p]), 64'd0);
            if (lat(d) > 0)
              chk($sformatf("hold dut%0d p%0d", d, p), 64'(dat[d][p*32 +: 32]), 64'(last[d][p]));
          end
        end
      end
    end
  end

  // Drive one cycle of stimulus and record what each configuration should answer.
  task automatic step(input bit we, input logic [5:0] wa, input logic [31:0] wd,
                      input logic [3:0] wm, input logic [1:0] re, input logic [11:0] ra);
    exp_t        e;
    logic [5:0]  a;
    @(posedge clk);
    #1;
    w_in = we; w_addr = wa; w_data = wd; w_mask = wm; r_in = re; r_addr = ra;
    for (int d = 0; d < ND; d++) begin
      if (busy[d]) begin
        busy_cnt[d]++;
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (re[p]) begin
            a = ra[p*6 +: 6];
            e.due = cyc + lat(d);
            e.dat = (int'(a) < dep(d)) ? mem[d][a] : 32'h0;
            if (rdw(d) && we && wa == a && int'(a) < dep(d)) e.dat = merge(e.dat, wd, wm);
            sbq[d][p].push_back(e);
          end
        end
        if (we && int'(wa) < dep(d)) mem[d][wa] = merge(mem[d][wa], wd, wm);
      end
    end
  endtask

  task automatic rnd_step();
    logic [5:0] wa;
    logic [5:0] a0;
    logic [5:0] a1;
    wa = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(44, 52)) : 6'($urandom_range(0, 63));
    a0 = ($urandom_range(0, 2) == 0) ? wa : 6'($urandom_range(0, 63));
    a1 = ($urandom_range(0, 2) == 0) ? wa : 6'($urandom_range(0, 63));
    step(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom), 2'($urandom), {a1, a0});
  endtask

  // Hold reset low n cycles; in-flight reads past the reset edge vanish and the model clears.
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b0; w_in = 1'b0; r_in = 2'b00;
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < NP; p++)
        while (sbq[d][p].size() > 0 && sbq[d][p][$].due > cyc) void'(sbq[d][p].pop_back());
      for (int a = 0; a < 64; a++) mem[d][a] = '0;
    end
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int d = 0; d < ND; d++) busy_cnt[d] = busy[d] ? 1 : 0;
  endtask

  task automatic wait_ready(input string tag, input bit rnd);
    int n;
    n = 0;
    while ((busy[0] || busy[1] || busy[2]) && n < 300) begin
      if (rnd) rnd_step();
      else step(1'b0, 6'd0, 32'h0, 4'h0, 2'b00, 12'd0);
      n++;
    end
    for (int d = 0; d < ND; d++) chk($sformatf("%s dut%0d", tag, d), 64'(busy_cnt[d]), 64'(dep(d)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; debugen = 1'b0;
    w_in = 1'b0; w_addr = '0; w_data = '0; w_mask = '0; r_in = '0; r_addr = '0;
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < NP; p++) last[d][p] = '0;

    do_reset(2);
    mon_en = 1'b1;
    for (int d = 0; d < ND; d++) chk($sformatf("reset_busy dut%0d", d), 64'(busy[d]), 64'd1);
    wait_ready("clear_len", 1'b0);

    // Every word reads back zero after the clear.
    for (int a = 0; a < 64; a++) step(1'b0, 6'd0, 32'h0, 4'h0, 2'b11, {6'(63 - a), 6'(a)});

    // Partial-byte overwrite, then dual-port read of two neighbouring words.
    step(1'b1, 6'd5, 32'hDEADBEEF, 4'hF, 2'b00, 12'd0);
    step(1'b1, 6'd5, 32'h0000AA00, 4'h2, 2'b00, 12'd0);
    step(1'b1, 6'd6, 32'h12345678, 4'hF, 2'b00, 12'd0);
    step(1'b0, 6'd0, 32'h0, 4'h0, 2'b11, {6'd6, 6'd5});
    repeat (4) step(1'b0, 6'd0, 32'h0, 4'h0, 2'b00, 12'd0);

    // Read-during-write on the same word from both ports.
    step(1'b1, 6'd9, 32'hAABBCCDD, 4'hF, 2'b00, 12'd0);
    step(1'b1, 6'd9, 32'h11223344, 4'h3, 2'b11, {6'd9, 6'd9});
    step(1'b0, 6'd0, 32'h0, 4'h0, 2'b11, {6'd9, 6'd9});

    // Depth boundary: 47 is the last word of the 48-deep parts, 50 lies beyond it.
    step(1'b1, 6'd50, 32'hCAFEF00D, 4'hF, 2'b00, 12'd0);
    step(1'b1, 6'd47, 32'h47474747, 4'hF, 2'b00, 12'd0);
    step(1'b0, 6'd0, 32'h0, 4'h0, 2'b11, {6'd47, 6'd50});
    step(1'b0, 6'd0, 32'h0, 4'h0, 2'b00, 12'd0);

    // Zero mask leaves the word alone.
    step(1'b1, 6'd47, 32'hFFFFFFFF, 4'h0, 2'b01, {6'd0, 6'd47});
    step(1'b0, 6'd0, 32'h0, 4'h0, 2'b01, {6'd0, 6'd47});

    for (int i = 0; i < 1200; i++) begin
      debugen = (i == 100 || i == 101);
      rnd_step();
    end
    debugen = 1'b0;

    // Reset straight after a read flushes the pipelines; a second reset mid-clear restarts it.
    rnd_step();
    step(1'b0, 6'd0, 32'h0, 4'h0, 2'b11, {6'd47, 6'd5});
    do_reset(1);
    repeat (30) rnd_step();
    do_reset(1);
    wait_ready("restart_len", 1'b1);

    for (int i = 0; i < 400; i++) rnd_step();
    repeat (5) step(1'b0, 6'd0, 32'h0, 4'h0, 2'b00, 12'd0);
    @(negedge clk);
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < NP; p++)
        chk($sformatf("drain dut%0d p%0d", d, p), 64'(sbq[d][p].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
